// File: rtl/v_wb_queue_if.sv
// Bundle of handshake and data signals between the vector execute stage,
// the writeback queue and the VRF write port.
// Optional bypass signals exist only when VWB_BYPASS_EN is defined.
interface v_wb_queue_if #(
  parameter int VREG_WIDTH = 512,
  parameter int LANES      = 16
);
  logic                  ex_valid_i;
  logic                  ex_ready_o;
  logic [4:0]            ex_vd_i;
  logic                  ex_scalar_i;
  logic [VREG_WIDTH-1:0] ex_result_i;
  logic                  flush_i;
  logic                  vrf_we_o;
  logic                  vrf_ready_i;
  logic [4:0]            vrf_waddr_o;
  logic [VREG_WIDTH-1:0] vrf_wdata_o;
  logic [LANES-1:0]      vrf_wmask_o;
  logic [31:0]           pend_o;
`ifdef VWB_BYPASS_EN
  logic [4:0]            byp_raddr_i;
  logic                  byp_hit_o;
  logic                  byp_partial_o;
  logic [VREG_WIDTH-1:0] byp_data_o;

  // Queue side
  modport slave (
    input  ex_valid_i, ex_vd_i, ex_scalar_i, ex_result_i, flush_i, vrf_ready_i, byp_raddr_i,
    output ex_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o, pend_o,
           byp_hit_o, byp_partial_o, byp_data_o
  );
  // Execute / VRF side
  modport master (
    output ex_valid_i, ex_vd_i, ex_scalar_i, ex_result_i, flush_i, vrf_ready_i, byp_raddr_i,
    input  ex_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o, pend_o,
           byp_hit_o, byp_partial_o, byp_data_o
  );
`else
  // Queue side
  modport slave (
    input  ex_valid_i, ex_vd_i, ex_scalar_i, ex_result_i, flush_i, vrf_ready_i,
    output ex_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o, pend_o
  );
  // Execute / VRF side
  modport master (
    output ex_valid_i, ex_vd_i, ex_scalar_i, ex_result_i, flush_i, vrf_ready_i,
    input  ex_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o, pend_o
  );
`endif
endinterface

// File: rtl/v_wb_queue.sv
// Vector writeback queue: in-order buffer of execute results draining into
// the VRF write port, with a pending-destination bitmap for hazard checks.
// Define VWB_BYPASS_EN to add a read bypass of the youngest queued result.
module v_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int VREG_WIDTH = 512,
  parameter int LANES      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  v_wb_queue_if.slave wb
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]            vd_mem_r     [DEPTH];
  logic                  scalar_mem_r [DEPTH];
  logic [VREG_WIDTH-1:0] data_mem_r   [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic [DEPTH-1:0] entry_valid_s;
  logic [31:0]      pend_s;

  // Acceptance depends on occupancy only, so a full queue refuses a push
  // even when the head drains in the same cycle.
  assign head_valid_s  = (count_r != {(AW+1){1'b0}});
  assign wb.ex_ready_o = (count_r != FULL_CNT);
  assign push_s        = wb.ex_valid_i && wb.ex_ready_o && !wb.flush_i;
  assign pop_s         = head_valid_s && wb.vrf_ready_i && !wb.flush_i;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (wb.flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through valid-entry gating.
  always_ff @(posedge clk) begin
    if (push_s) begin
      vd_mem_r[wr_ptr_r]     <= wb.ex_vd_i;
      scalar_mem_r[wr_ptr_r] <= wb.ex_scalar_i;
      data_mem_r[wr_ptr_r]   <= wb.ex_result_i;
    end
  end

  // Mark which physical slots hold live entries (age from head < count).
  always_comb begin
    entry_valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid_s[i] = ({1'b0, AW'(i) - rd_ptr_r} < count_r);
    end
  end

  // Pending-destination bitmap: OR of one-hot vd over live entries.
  always_comb begin
    pend_s = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_s = pend_s | (entry_valid_s[i] ? (32'h1 << vd_mem_r[i]) : 32'h0);
    end
  end
  assign wb.pend_o = pend_s;

  // Head entry drives the VRF port; outputs read as zero while empty.
  assign wb.vrf_we_o    = head_valid_s;
  assign wb.vrf_waddr_o = head_valid_s ? vd_mem_r[rd_ptr_r] : 5'd0;
  assign wb.vrf_wdata_o = head_valid_s ? data_mem_r[rd_ptr_r] : {VREG_WIDTH{1'b0}};
  assign wb.vrf_wmask_o = !head_valid_s          ? {LANES{1'b0}} :
                          scalar_mem_r[rd_ptr_r] ? {{(LANES-1){1'b0}}, 1'b1} :
                                                   {LANES{1'b1}};

`ifdef VWB_BYPASS_EN
  logic                  byp_hit_s;
  logic                  byp_partial_s;
  logic [VREG_WIDTH-1:0] byp_data_s;

  // Walk entries oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [AW-1:0] idx;
    idx           = {AW{1'b0}};
    byp_hit_s     = 1'b0;
    byp_partial_s = 1'b0;
    byp_data_s    = {VREG_WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_r + AW'(k);
      if (((AW+1)'(k) < count_r) && (vd_mem_r[idx] == wb.byp_raddr_i)) begin
        byp_hit_s     = !scalar_mem_r[idx];
        byp_partial_s = scalar_mem_r[idx];
        byp_data_s    = data_mem_r[idx];
      end else begin
        byp_hit_s     = byp_hit_s;
        byp_partial_s = byp_partial_s;
        byp_data_s    = byp_data_s;
      end
    end
  end

  assign wb.byp_hit_o     = byp_hit_s;
  assign wb.byp_partial_o = byp_partial_s;
  assign wb.byp_data_o    = byp_data_s;
`endif

endmodule
